// File: rtl/pc_fetch_sequencer_pkg.sv
// pc_seq_defs: shared definitions for the PC fetch sequencer slice.
//   pc_state_e        - FSM state encodings (also exported on the debug port)
//   DEF_RESET_VECTOR  - default address loaded into the PC after reset
//   DEF_MEM_TIMEOUT   - default memory-read wait limit in cycles
package pc_seq_defs;

    typedef enum logic [2:0] {
        RST_LOAD   = 3'd0,
        IDLE       = 3'd1,
        FETCH_ADDR = 3'd2,
        FETCH_WAIT = 3'd3,
        DECODE     = 3'd4,
        EXECUTE    = 3'd5,
        WRITE_PC   = 3'd6,
        HALT       = 3'd7
    } pc_state_e;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam int unsigned DEF_MEM_TIMEOUT  = 15;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// pc_fetch_sequencer_if: bus between the fetch sequencer and the datapath.
//   PC register : pc_q (register output), pc_d / pc_enable / pc_inc (controls)
//   Memory      : mar_load, mem_read, mem_ready, ir_load
//   Execute unit: exec_start, exec_done, branch_taken, branch_target
// master = sequencer side, slave = datapath side.
interface pc_fetch_sequencer_if;

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        pc_enable;
    logic        pc_inc;
    logic        mar_load;
    logic        mem_read;
    logic        mem_ready;
    logic        ir_load;
    logic        exec_start;
    logic        exec_done;
    logic        branch_taken;
    logic [31:0] branch_target;

    modport master (
        input  pc_q, mem_ready, exec_done, branch_taken, branch_target,
        output pc_d, pc_enable, pc_inc, mar_load, mem_read, ir_load, exec_start
    );

    modport slave (
        output pc_q, mem_ready, exec_done, branch_taken, branch_target,
        input  pc_d, pc_enable, pc_inc, mar_load, mem_read, ir_load, exec_start
    );

endinterface

// File: rtl/pc_fetch_sequencer_timer.sv
// fetch_timeout_timer: counts memory wait cycles for one fetch.
//   clk, clr_n : clock, asynchronous active-low reset
//   clear      : restart the count (start of a fetch)
//   count_en   : one more wait cycle elapsed without mem_ready
//   expire     : the current wait cycle is the MEM_TIMEOUT-th one
module fetch_timeout_timer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic clr_n,
    input  logic clear,
    input  logic count_en,
    output logic expire
);

    localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);

    logic [TW-1:0] timer;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            timer <= '0;
        end else if (clear) begin
            timer <= '0;
        end else if (count_en) begin
            timer <= timer + TW'(1);
        end
    end

    // timer holds the number of completed wait cycles, so the
    // MEM_TIMEOUT-th wait cycle is the one where it reads MEM_TIMEOUT-1.
    assign expire = (timer == TW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: fetch/execute control FSM driving the PC register.
//   clk, clr_n  : clock, asynchronous active-low reset
//   run         : level, permits fetching
//   halt_req    : request halt at next instruction boundary (latched)
//   bus         : PC register / memory / execute-unit handshakes (master)
//   halted      : FSM is in HALT
//   fetch_err   : sticky memory-timeout flag
//   instr_count : retired instructions, wraps
//   state       : current state encoding (debug)
module pc_fetch_sequencer
    import pc_seq_defs::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter int unsigned MEM_TIMEOUT  = DEF_MEM_TIMEOUT,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 run,
    input  logic                 halt_req,
    pc_fetch_sequencer_if.master bus,
    output logic                 halted,
    output logic                 fetch_err,
    output logic [CNT_W-1:0]     instr_count,
    output logic [2:0]           state
);

    pc_state_e   cur_st, nxt_st;
    logic        halt_pending;
    logic [31:0] tgt_q;
    logic        timer_clear, timer_count, timer_expire;
    logic        retire, set_err, halt_now;
    logic        halted_c;

    fetch_timeout_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk      (clk),
        .clr_n    (clr_n),
        .clear    (timer_clear),
        .count_en (timer_count),
        .expire   (timer_expire)
    );

    // A halt_req arriving in the retiring cycle itself must still stop
    // the machine at this boundary, hence the OR with the raw request.
    assign halt_now = halt_pending | halt_req;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cur_st <= RST_LOAD;
        end else begin
            cur_st <= nxt_st;
        end
    end

    always_comb begin
        nxt_st         = cur_st;
        bus.pc_d       = '0;
        bus.pc_enable  = 1'b0;
        bus.pc_inc     = 1'b0;
        bus.mar_load   = 1'b0;
        bus.mem_read   = 1'b0;
        bus.ir_load    = 1'b0;
        bus.exec_start = 1'b0;
        halted_c       = 1'b0;
        timer_clear    = 1'b0;
        timer_count    = 1'b0;
        retire         = 1'b0;
        set_err        = 1'b0;

        case (cur_st)
            RST_LOAD: begin
                bus.pc_enable = 1'b1;
                bus.pc_d      = RESET_VECTOR;
                nxt_st        = IDLE;
            end
            IDLE: begin
                if (halt_now)  nxt_st = HALT;
                else if (run)  nxt_st = FETCH_ADDR;
            end
            FETCH_ADDR: begin
                bus.mar_load  = 1'b1;
                bus.pc_enable = 1'b1;
                bus.pc_inc    = 1'b1;
                bus.pc_d      = bus.pc_q;
                timer_clear   = 1'b1;
                nxt_st        = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                bus.mem_read = 1'b1;
                if (bus.mem_ready) begin
                    bus.ir_load = 1'b1;
                    nxt_st      = DECODE;
                end else if (timer_expire) begin
                    set_err = 1'b1;
                    nxt_st  = HALT;
                end else begin
                    timer_count = 1'b1;
                end
            end
            DECODE: begin
                bus.exec_start = 1'b1;
                nxt_st         = EXECUTE;
            end
            EXECUTE: begin
                if (bus.exec_done) begin
                    if (bus.branch_taken) begin
                        nxt_st = WRITE_PC;
                    end else begin
                        retire = 1'b1;
                        nxt_st = halt_now ? HALT : (run ? FETCH_ADDR : IDLE);
                    end
                end
            end
            WRITE_PC: begin
                bus.pc_enable = 1'b1;
                bus.pc_d      = tgt_q;
                retire        = 1'b1;
                nxt_st        = halt_now ? HALT : (run ? FETCH_ADDR : IDLE);
            end
            HALT: begin
                halted_c = 1'b1;
            end
            default: nxt_st = RST_LOAD;
        endcase

        // Strobes are forced low while reset is held so that RST_LOAD's
        // PC load only happens on the first cycle after release.
        if (!clr_n) begin
            bus.pc_d       = '0;
            bus.pc_enable  = 1'b0;
            bus.pc_inc     = 1'b0;
            bus.mar_load   = 1'b0;
            bus.mem_read   = 1'b0;
            bus.ir_load    = 1'b0;
            bus.exec_start = 1'b0;
            halted_c       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            halt_pending <= 1'b0;
            fetch_err    <= 1'b0;
            instr_count  <= '0;
            tgt_q        <= '0;
        end else begin
            if (halt_req) halt_pending <= 1'b1;
            if (set_err)  fetch_err    <= 1'b1;
            if (retire)   instr_count  <= instr_count + CNT_W'(1);
            if (cur_st == EXECUTE && bus.exec_done) tgt_q <= bus.branch_target;
        end
    end

    assign halted = halted_c;
    assign state  = cur_st;

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Control FSM that sequences the 32-bit program-counter register (the one with enable/incPC that computes Q<=D+1 or Q<=D) through the fetch/execute cycle of the CPU. It drives the PC's D/enable/incPC inputs for three operations: reset-vector load, post-fetch increment and branch load. It also strobes MAR/memory-read/IR loads, hands off to the execute unit and guards memory reads with a timeout.

Parameters:
RESET_VECTOR, 32'h0000_0000, address loaded into PC after reset
MEM_TIMEOUT, 15, max cycles waiting for mem_ready before fault (≥2)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
clr_n  in  1  asynchronous active-low reset
run  in  1  level: permit fetching
halt_req  in  1  request halt at next instruction boundary
mem_ready  in  1  memory read data valid this cycle
exec_done  in  1  execute unit finished current instruction
branch_taken  in  1  qualifies branch_target; sampled only with exec_done
branch_target  in  32  new PC on taken branch
pc_q  in  32  current PC register output
pc_d  out  32  PC register D input
pc_enable  out  1  PC register enable
pc_inc  out  1  PC register incPC
mar_load  out  1  MAR captures pc_q
mem_read  out  1  memory read request
ir_load  out  1  IR captures memory data
exec_start  out  1  one-cycle start pulse to execute unit
halted  out  1  FSM in HALT
fetch_err  out  1  sticky memory-timeout flag
instr_count  out  CNT_W  retired instructions, wraps at 2^CNT_W
state  out  3  current state encoding (debug)

Behaviour:
- Async reset (clr_n=0): state=RST_LOAD; instr_count=0, fetch_err=0, halt_pending=0, timer=0. All strobes are decoded from state, so during reset pc_enable=0, pc_inc=0, mar_load=0, mem_read=0, ir_load=0, exec_start=0, halted=0 and pc_d=0. Reset mid-operation aborts immediately, with no completion of a pending fetch or branch.
- States and encodings: RST_LOAD=0, IDLE=1, FETCH_ADDR=2, FETCH_WAIT=3, DECODE=4, EXECUTE=5, WRITE_PC=6, HALT=7.
- RST_LOAD (1 cycle): pc_enable=1, pc_inc=0, pc_d=RESET_VECTOR. Next state is IDLE.
- IDLE: no strobes. halt_pending or halt_req → HALT; else run → FETCH_ADDR.
- FETCH_ADDR (1 cycle): mar_load=1, pc_enable=1, pc_inc=1, pc_d=pc_q. On the same edge, MAR takes the old PC and PC becomes PC+1. Timer clears. Next state is FETCH_WAIT.
- FETCH_WAIT: mem_read=1.
  - mem_ready=1: ir_load=1 that cycle (combinational on mem_ready) → DECODE.
  - Otherwise timer increments. If mem_ready is still 0 on the MEM_TIMEOUT-th wait cycle: fetch_err←1 → HALT.
- DECODE (1 cycle): exec_start=1. Next state is EXECUTE.
- EXECUTE: waits for exec_done.
  - exec_done with branch_taken → WRITE_PC.
  - exec_done without branch_taken → boundary.
- WRITE_PC (1 cycle): pc_enable=1, pc_inc=0, pc_d=branch_target, registered at the exec_done edge. Then boundary.
- Boundary (taken on the exit edge): instr_count+1, wrapping. Then halt_pending → HALT; else run → FETCH_ADDR; else IDLE.
- halt_req handling:
  - Latched into halt_pending in any state.
  - Never aborts an instruction in progress.
  - exec_done and halt_req in the same cycle: the instruction retires (branch still written), then HALT.
- HALT: halted=1, no other strobes. Exits only via clr_n.
- pc_enable is asserted only in RST_LOAD, FETCH_ADDR and WRITE_PC. pc_d is 0 in all other states.
- run dropping mid-instruction has no effect until the boundary.

Decomposition:
- Shared include/package pc_seq_defs: state encodings as localparams, default RESET_VECTOR and MEM_TIMEOUT.
- One natural sub-module, fetch_timeout_timer: clear, count-enable, expire output at MEM_TIMEOUT. The FSM stays in pc_fetch_sequencer.

Test Plan:
1. Reset vector: RESET_VECTOR=32'h100, release clr_n → one cycle pc_enable=1, pc_inc=0, pc_d=32'h100; PC reg reads 32'h100; state=IDLE.
2. Sequential fetch: run=1, mem_ready 2 cycles after mem_read, exec_done 3 cycles after exec_start, no branch, 3 instructions → MAR sees 100/101/102, PC=103, instr_count=3, exactly one exec_start per instruction.
3. Branch: exec_done with branch_taken=1, branch_target=32'h40 → WRITE_PC cycle pc_d=32'h40, pc_inc=0; next FETCH_ADDR has MAR=32'h40, PC becomes 32'h41.
4. Timeout: MEM_TIMEOUT=4, mem_ready held 0 → fetch_err=1 and halted=1 after the 4th wait cycle; instr_count unchanged; no ir_load.
5. Halt race: halt_req pulsed with exec_done and branch_taken (target 32'h80) → PC=32'h80, instr_count+1, then HALT. halt_req pulsed in FETCH_WAIT → current instruction completes first.
6. Reset mid-fetch: clr_n low during FETCH_WAIT → mem_read drops the same cycle; after release, RST_LOAD is repeated and fetch_err/instr_count=0.
